// File: rtl/hazard_ctrl_if.sv
// ============================================================================
//  Module      : hazard_ctrl_if
//  Description : Signal bundle between the WISC pipeline datapath and the
//                hazard/flush controller. The master modport is the pipeline
//                side: it supplies register indices and stage status, and it
//                receives the stall/bubble/flush/freeze controls. The slave
//                modport is the controller side.
//  Parameters  : REG_W  - register index width
//                PERF_W - stall performance counter width
//  Signals     : Rs_d, Rt_d, RsUse_d, RtUse_d, nop_d   decode-stage operands
//                Rd_x, RegWrite_x, MemRead_x            EX-stage producer
//                Rd_m, RegWrite_m                       MEM-stage producer
//                branchTaken_m, halt_m, dmem_busy       MEM-stage events
//                stall_fd, bubble_dx, freeze            hold/insert controls
//                flush_fd, flush_dx                     squash controls
//                hz_state, stall_cnt                    status / perf counter
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hazard_ctrl_if #(
   parameter int REG_W  = 3,
   parameter int PERF_W = 16
);
   logic [REG_W-1:0]  Rs_d;
   logic [REG_W-1:0]  Rt_d;
   logic              RsUse_d;
   logic              RtUse_d;
   logic              nop_d;
   logic [REG_W-1:0]  Rd_x;
   logic              RegWrite_x;
   logic              MemRead_x;
   logic [REG_W-1:0]  Rd_m;
   logic              RegWrite_m;
   logic              branchTaken_m;
   logic              halt_m;
   logic              dmem_busy;
   logic              stall_fd;
   logic              bubble_dx;
   logic              freeze;
   logic              flush_fd;
   logic              flush_dx;
   logic [1:0]        hz_state;
   logic [PERF_W-1:0] stall_cnt;

   modport master (
      output Rs_d, Rt_d, RsUse_d, RtUse_d, nop_d,
      output Rd_x, RegWrite_x, MemRead_x, Rd_m, RegWrite_m,
      output branchTaken_m, halt_m, dmem_busy,
      input  stall_fd, bubble_dx, freeze, flush_fd, flush_dx,
      input  hz_state, stall_cnt
   );

   modport slave (
      input  Rs_d, Rt_d, RsUse_d, RtUse_d, nop_d,
      input  Rd_x, RegWrite_x, MemRead_x, Rd_m, RegWrite_m,
      input  branchTaken_m, halt_m, dmem_busy,
      output stall_fd, bubble_dx, freeze, flush_fd, flush_dx,
      output hz_state, stall_cnt
   );
endinterface

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Hazard and flush controller for the 5-stage WISC pipeline.
//                Detects RAW hazards in decode, issues the required number of
//                bubbles through a small RUN/HAZ/HALTED FSM with a bubble
//                counter (no re-detection while bubbles are draining), flushes
//                on taken branches, freezes everything while data memory is
//                busy and latches HALT until reset.
//  Config      : FWD_EN - when defined, EX->EX and MEM->EX forwarding exists,
//                so only load-use hazards stall (at most one bubble). When
//                undefined, no forwarding; EX producers cost 2 bubbles and
//                MEM producers 1 (register file writes before it is read).
//  Ports       : clk, rst       clock, asynchronous active-high reset
//                hz (slave)     pipeline hazard bundle, see hazard_ctrl_if
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl #(
   parameter int REG_W  = 3,
   parameter int PERF_W = 16
) (
   input  wire logic     clk,
   input  wire logic     rst,
   hazard_ctrl_if.slave  hz
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_HAZ    = 2'd1,
      ST_HALTED = 2'd2
   } hz_state_t;

   localparam logic [PERF_W-1:0] c_perf_one = {{(PERF_W-1){1'b0}}, 1'b1};

   hz_state_t         r_state;
   logic [1:0]        r_cnt;
   logic [PERF_W-1:0] r_stall_cnt;

   hz_state_t         w_state_nxt;
   logic [1:0]        w_cnt_nxt;
   logic [1:0]        w_need_rs;
   logic [1:0]        w_need_rt;
   logic [1:0]        w_need;
   logic              w_stall_fd;
   logic              w_bubble_dx;
   logic              w_freeze;
   logic              w_flush_fd;
   logic              w_flush_dx;

   logic [REG_W-1:0]  w_rs;
   logic [REG_W-1:0]  w_rt;
   logic [REG_W-1:0]  w_rd_x;
   logic [REG_W-1:0]  w_rd_m;

   assign w_rs   = hz.Rs_d;
   assign w_rt   = hz.Rt_d;
   assign w_rd_x = hz.Rd_x;
   assign w_rd_m = hz.Rd_m;

   // Bubbles one source operand needs before its producer's value is reachable.
   function automatic logic [1:0] op_need(
      input logic             use_op,
      input logic [REG_W-1:0] src,
      input logic [REG_W-1:0] rd_x,
      input logic             wr_x,
      input logic             load_x,
      input logic [REG_W-1:0] rd_m,
      input logic             wr_m
   );
      logic [1:0] n;
      n = 2'd0;
`ifdef FWD_EN
      // Forwarding covers everything except a load result still in EX.
      if (use_op && wr_x && load_x && (src == rd_x)) n = 2'd1;
`else
      if (use_op && wr_x && (src == rd_x))      n = 2'd2;
      else if (use_op && wr_m && (src == rd_m)) n = 2'd1;
`endif
      return n;
   endfunction

   // Inputs that only matter in one build configuration.
   logic w_unused_cfg;
`ifdef FWD_EN
   assign w_unused_cfg = ^{w_rd_m, hz.RegWrite_m};
`else
   assign w_unused_cfg = hz.MemRead_x;
`endif

   always_comb begin
      w_need_rs = 2'd0;
      w_need_rt = 2'd0;
      if (!hz.nop_d) begin
         w_need_rs = op_need(hz.RsUse_d, w_rs, w_rd_x, hz.RegWrite_x,
                             hz.MemRead_x, w_rd_m, hz.RegWrite_m);
         w_need_rt = op_need(hz.RtUse_d, w_rt, w_rd_x, hz.RegWrite_x,
                             hz.MemRead_x, w_rd_m, hz.RegWrite_m);
      end
      w_need = (w_need_rs > w_need_rt) ? w_need_rs : w_need_rt;
   end

   // Output decode and next-state logic. While reset is asserted every
   // control is forced low so a reset in the middle of a stall takes effect
   // on the outputs immediately, not only on the state.
   always_comb begin
      w_stall_fd  = 1'b0;
      w_bubble_dx = 1'b0;
      w_freeze    = 1'b0;
      w_flush_fd  = 1'b0;
      w_flush_dx  = 1'b0;
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;

      if (!rst) begin
         w_freeze = hz.dmem_busy;
         if (r_state == ST_HALTED) begin
            w_stall_fd = 1'b1;
            w_flush_dx = 1'b1;
         end else if (!hz.dmem_busy) begin
            // A frozen cycle leaves FSM and counter untouched; a branch held
            // in MEM across the freeze is therefore taken here, afterwards.
            if (hz.branchTaken_m) begin
               w_flush_fd  = 1'b1;
               w_flush_dx  = 1'b1;
               w_state_nxt = ST_RUN;
               w_cnt_nxt   = 2'd0;
            end else if (r_state == ST_HAZ) begin
               w_stall_fd  = 1'b1;
               w_bubble_dx = 1'b1;
               if (r_cnt <= 2'd1) begin
                  w_state_nxt = ST_RUN;
                  w_cnt_nxt   = 2'd0;
               end else begin
                  w_cnt_nxt   = r_cnt - 2'd1;
               end
            end else if (w_need != 2'd0) begin
               w_stall_fd  = 1'b1;
               w_bubble_dx = 1'b1;
               if (w_need > 2'd1) begin
                  w_state_nxt = ST_HAZ;
                  w_cnt_nxt   = w_need - 2'd1;
               end
            end
            // Halt has priority over a same-cycle branch redirect.
            if (hz.halt_m) begin
               w_state_nxt = ST_HALTED;
               w_cnt_nxt   = 2'd0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_RUN;
         r_cnt       <= 2'd0;
         r_stall_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if ((w_stall_fd || w_freeze) && (r_stall_cnt != {PERF_W{1'b1}}))
            r_stall_cnt <= r_stall_cnt + c_perf_one;
      end
   end

   assign hz.stall_fd  = w_stall_fd;
   assign hz.bubble_dx = w_bubble_dx;
   assign hz.freeze    = w_freeze;
   assign hz.flush_fd  = w_flush_fd;
   assign hz.flush_dx  = w_flush_dx;
   assign hz.hz_state  = r_state;
   assign hz.stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Self-checking bench for hazard_ctrl. Table of single-cycle
//                detection vectors, hand-written multi-cycle sequences and a
//                randomized phase checked against a bubble-owed reference
//                model. Works with and without FWD_EN defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

   localparam int c_reg_w  = 3;
   localparam int c_perf_w = 16;
   localparam int c_sat    = (1 << c_perf_w) - 1;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   hazard_ctrl_if #(.REG_W(c_reg_w), .PERF_W(c_perf_w)) hif ();

   hazard_ctrl #(.REG_W(c_reg_w), .PERF_W(c_perf_w)) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] rs, rt;
      logic       rsu, rtu, nop;
      logic [2:0] rdx;
      logic       rwx, mrx;
      logic [2:0] rdm;
      logic       rwm;
      logic       exp_stall;
      logic [1:0] exp_next;
   } vec_t;

   vec_t vecs[10];

   // Reference model state: bubbles still owed, halt latch, stall cycle count.
   int m_owed;
   bit m_halted;
   int m_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      hif.Rs_d = '0; hif.Rt_d = '0; hif.RsUse_d = 0; hif.RtUse_d = 0; hif.nop_d = 0;
      hif.Rd_x = '0; hif.RegWrite_x = 0; hif.MemRead_x = 0;
      hif.Rd_m = '0; hif.RegWrite_m = 0;
      hif.branchTaken_m = 0; hif.halt_m = 0; hif.dmem_busy = 0;
   endtask

   task automatic do_reset();
      clear_in();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      m_owed = 0; m_halted = 0; m_cnt = 0;
   endtask

   function automatic vec_t mk(input int rs, rt, rsu, rtu, nop, rdx, rwx, mrx, rdm, rwm,
                               s_nf, n_nf, s_f, n_f);
      vec_t v;
      v.rs = 3'(rs); v.rt = 3'(rt); v.rsu = 1'(rsu); v.rtu = 1'(rtu); v.nop = 1'(nop);
      v.rdx = 3'(rdx); v.rwx = 1'(rwx); v.mrx = 1'(mrx); v.rdm = 3'(rdm); v.rwm = 1'(rwm);
`ifdef FWD_EN
      v.exp_stall = 1'(s_f);  v.exp_next = 2'(n_f);
`else
      v.exp_stall = 1'(s_nf); v.exp_next = 2'(n_nf);
`endif
      return v;
   endfunction

   // Bubbles required by one operand, straight from the hazard rules.
   function automatic int need_op(input bit use_op, input int src);
`ifdef FWD_EN
      if (use_op && hif.RegWrite_x && hif.MemRead_x && src == int'(hif.Rd_x)) return 1;
      return 0;
`else
      if (use_op && hif.RegWrite_x && src == int'(hif.Rd_x)) return 2;
      if (use_op && hif.RegWrite_m && src == int'(hif.Rd_m)) return 1;
      return 0;
`endif
   endfunction

   function automatic int need_total();
      int a, b;
      if (hif.nop_d) return 0;
      a = need_op(hif.RsUse_d, int'(hif.Rs_d));
      b = need_op(hif.RtUse_d, int'(hif.Rt_d));
      return (a > b) ? a : b;
   endfunction

   // Compare all outputs against the model for the current cycle, then
   // advance the model to the next cycle.
   task automatic model_cycle();
      int n;
      bit e_st, e_bu, e_fr, e_ffd, e_fdx;
      int e_state;
      n = need_total();
      e_st = 0; e_bu = 0; e_ffd = 0; e_fdx = 0;
      e_fr = hif.dmem_busy;
      if (m_halted) begin
         e_st = 1; e_fdx = 1; e_state = 2;
      end else begin
         e_state = (m_owed > 0) ? 1 : 0;
         if (!hif.dmem_busy) begin
            if (hif.branchTaken_m) begin
               e_ffd = 1; e_fdx = 1;
            end else if (m_owed > 0 || n > 0) begin
               e_st = 1; e_bu = 1;
            end
         end
      end
      chk("rnd_stall_fd",  32'(hif.stall_fd),  32'(e_st));
      chk("rnd_bubble_dx", 32'(hif.bubble_dx), 32'(e_bu));
      chk("rnd_freeze",    32'(hif.freeze),    32'(e_fr));
      chk("rnd_flush_fd",  32'(hif.flush_fd),  32'(e_ffd));
      chk("rnd_flush_dx",  32'(hif.flush_dx),  32'(e_fdx));
      chk("rnd_hz_state",  32'(hif.hz_state),  32'(e_state));
      chk("rnd_stall_cnt", 32'(hif.stall_cnt), 32'(m_cnt));
      if (!m_halted && !hif.dmem_busy) begin
         if (hif.branchTaken_m)  m_owed = 0;
         else if (m_owed > 0)    m_owed = m_owed - 1;
         else if (n > 0)         m_owed = n - 1;
         if (hif.halt_m) begin m_halted = 1; m_owed = 0; end
      end
      if ((e_st || e_fr) && m_cnt < c_sat) m_cnt = m_cnt + 1;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      clear_in();

      //                rs rt su tu nop rdx wx mx rdm wm  nofwd  fwd
      vecs[0] = mk(3, 0, 1, 0, 0, 3, 1, 0, 0, 0,  1, 1,  0, 0);
      vecs[1] = mk(0, 5, 0, 1, 0, 5, 1, 1, 0, 0,  1, 1,  1, 0);
      vecs[2] = mk(2, 0, 1, 0, 0, 6, 1, 0, 2, 1,  1, 0,  0, 0);
      vecs[3] = mk(3, 0, 1, 0, 1, 3, 1, 1, 3, 1,  0, 0,  0, 0);
      vecs[4] = mk(3, 0, 0, 0, 0, 3, 1, 1, 3, 1,  0, 0,  0, 0);
      vecs[5] = mk(0, 0, 1, 0, 0, 0, 1, 1, 0, 0,  1, 1,  1, 0);
      vecs[6] = mk(4, 0, 1, 0, 0, 4, 0, 1, 4, 1,  1, 0,  0, 0);
      vecs[7] = mk(1, 2, 1, 1, 0, 2, 1, 0, 1, 1,  1, 1,  0, 0);
      vecs[8] = mk(0, 7, 0, 1, 0, 7, 0, 0, 7, 1,  1, 0,  0, 0);
      vecs[9] = mk(1, 2, 1, 1, 0, 3, 1, 1, 4, 1,  0, 0,  0, 0);

      // Reset state
      do_reset();
      #2;
      chk("reset_stall_fd",  32'(hif.stall_fd),  0);
      chk("reset_flush_dx",  32'(hif.flush_dx),  0);
      chk("reset_hz_state",  32'(hif.hz_state),  0);
      chk("reset_stall_cnt", 32'(hif.stall_cnt), 0);

      // Single-cycle detection table
      for (int i = 0; i < 10; i++) begin
         do_reset();
         hif.Rs_d = vecs[i].rs; hif.Rt_d = vecs[i].rt;
         hif.RsUse_d = vecs[i].rsu; hif.RtUse_d = vecs[i].rtu; hif.nop_d = vecs[i].nop;
         hif.Rd_x = vecs[i].rdx; hif.RegWrite_x = vecs[i].rwx; hif.MemRead_x = vecs[i].mrx;
         hif.Rd_m = vecs[i].rdm; hif.RegWrite_m = vecs[i].rwm;
         #2;
         chk($sformatf("vec%0d_stall_fd", i),  32'(hif.stall_fd),  32'(vecs[i].exp_stall));
         chk($sformatf("vec%0d_bubble_dx", i), 32'(hif.bubble_dx), 32'(vecs[i].exp_stall));
         tick();
         chk($sformatf("vec%0d_next_state", i), 32'(hif.hz_state), 32'(vecs[i].exp_next));
      end

`ifndef FWD_EN
      // EX producer: exactly two bubbles, states 0,1,0
      do_reset();
      hif.Rd_x = 3; hif.RegWrite_x = 1; hif.Rs_d = 3; hif.RsUse_d = 1;
      #2;
      chk("seq1_c0_stall", 32'(hif.stall_fd), 1);
      chk("seq1_c0_state", 32'(hif.hz_state), 0);
      tick(); #2;
      chk("seq1_c1_stall", 32'(hif.stall_fd), 1);
      chk("seq1_c1_bubble", 32'(hif.bubble_dx), 1);
      chk("seq1_c1_state", 32'(hif.hz_state), 1);
      tick(); clear_in(); #2;
      chk("seq1_c2_stall", 32'(hif.stall_fd), 0);
      chk("seq1_c2_state", 32'(hif.hz_state), 0);
      chk("seq1_stall_cnt", 32'(hif.stall_cnt), 2);

      // Branch while in HAZ
      do_reset();
      hif.Rd_x = 3; hif.RegWrite_x = 1; hif.Rs_d = 3; hif.RsUse_d = 1;
      tick();
      clear_in(); hif.branchTaken_m = 1; #2;
      chk("seq3_flush_fd", 32'(hif.flush_fd), 1);
      chk("seq3_flush_dx", 32'(hif.flush_dx), 1);
      chk("seq3_stall_fd", 32'(hif.stall_fd), 0);
      tick(); clear_in(); #2;
      chk("seq3_state", 32'(hif.hz_state), 0);
      chk("seq3_stall_after", 32'(hif.stall_fd), 0);

      // Memory busy during HAZ, with a held branch pending on a later freeze
      do_reset();
      hif.Rd_x = 3; hif.RegWrite_x = 1; hif.Rs_d = 3; hif.RsUse_d = 1;
      tick();
      clear_in();
      chk("seq4_cnt_before", 32'(hif.stall_cnt), 1);
      hif.dmem_busy = 1;
      for (int i = 0; i < 3; i++) begin
         #2;
         chk($sformatf("seq4_freeze%0d", i), 32'(hif.freeze), 1);
         chk($sformatf("seq4_stall%0d", i), 32'(hif.stall_fd), 0);
         chk($sformatf("seq4_state%0d", i), 32'(hif.hz_state), 1);
         tick();
      end
      hif.dmem_busy = 0; #2;
      chk("seq4_last_bubble", 32'(hif.bubble_dx), 1);
      tick(); #2;
      chk("seq4_state_done", 32'(hif.hz_state), 0);
      chk("seq4_stall_cnt", 32'(hif.stall_cnt), 5);
      hif.dmem_busy = 1; hif.branchTaken_m = 1; #2;
      chk("seq4_frozen_flush", 32'(hif.flush_fd), 0);
      tick(); hif.dmem_busy = 0; #2;
      chk("seq4_pending_flush", 32'(hif.flush_fd), 1);
      tick(); clear_in();

      // Asynchronous reset in the middle of HAZ
      do_reset();
      hif.Rd_x = 3; hif.RegWrite_x = 1; hif.Rs_d = 3; hif.RsUse_d = 1;
      tick(); #2;
      chk("seq6_in_haz", 32'(hif.hz_state), 1);
      rst = 1'b1; #1;
      chk("seq6_state", 32'(hif.hz_state), 0);
      chk("seq6_cnt", 32'(hif.stall_cnt), 0);
      chk("seq6_stall", 32'(hif.stall_fd), 0);
      tick(); rst = 1'b0; clear_in();
`endif

      // Halt beats branch; HALTED persists; reset clears all outputs
      do_reset();
      hif.halt_m = 1; hif.branchTaken_m = 1;
      tick(); clear_in(); #2;
      chk("seq5_state", 32'(hif.hz_state), 2);
      chk("seq5_flush_dx", 32'(hif.flush_dx), 1);
      chk("seq5_flush_fd", 32'(hif.flush_fd), 0);
      for (int i = 0; i < 12; i++) begin
         chk($sformatf("seq5_hold%0d", i), 32'(hif.stall_fd), 1);
         tick(); #2;
      end
      rst = 1'b1; #1;
      chk("seq5_rst_stall",  32'(hif.stall_fd),  0);
      chk("seq5_rst_flush",  32'(hif.flush_dx),  0);
      chk("seq5_rst_bubble", 32'(hif.bubble_dx), 0);
      chk("seq5_rst_freeze", 32'(hif.freeze),    0);
      chk("seq5_rst_state",  32'(hif.hz_state),  0);
      chk("seq5_rst_cnt",    32'(hif.stall_cnt), 0);
      tick(); rst = 1'b0;

      // Randomized phase against the reference model
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 149) == 0) begin
            do_reset();
            #2;
            chk("rnd_reset_state", 32'(hif.hz_state), 0);
            tick();
         end else begin
            hif.Rs_d = 3'($urandom_range(0, 7));
            hif.Rt_d = 3'($urandom_range(0, 7));
            hif.RsUse_d = 1'($urandom);
            hif.RtUse_d = 1'($urandom);
            hif.nop_d = ($urandom_range(0, 7) == 0);
            hif.Rd_x = 3'($urandom_range(0, 7));
            hif.RegWrite_x = 1'($urandom);
            hif.MemRead_x = 1'($urandom);
            hif.Rd_m = 3'($urandom_range(0, 7));
            hif.RegWrite_m = 1'($urandom);
            hif.branchTaken_m = ($urandom_range(0, 9) == 0);
            hif.dmem_busy = ($urandom_range(0, 7) == 0);
            hif.halt_m = ($urandom_range(0, 99) == 0);
            #2;
            model_cycle();
            tick();
         end
      end

      // Performance counter saturation while halted
      do_reset();
      hif.halt_m = 1;
      tick(); clear_in();
      for (int c = 0; c < c_sat + 5; c++) @(posedge clk);
      #2;
      chk("sat_stall_cnt", 32'(hif.stall_cnt), 32'(c_sat));
      tick(); #2;
      chk("sat_hold", 32'(hif.stall_cnt), 32'(c_sat));
      chk("sat_state", 32'(hif.hz_state), 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
